// File: rtl/frame_buffer_scanner_pkg.sv
// Shared types and geometry helpers for the frame buffer read-side scanner.
package scanner_pkg;

    // Scanner sequencing states: prefetch, shift out, latch, lit hold.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // Cycles spent in FETCH to cover the registered RAM address path.
    localparam int FETCH_CYCLES = 2;

    // Words per row for a given column index width.
    function automatic int cols_of(input int col_bits);
        return 1 << col_bits;
    endfunction

    // Rows per frame for a given row index width.
    function automatic int rows_of(input int row_bits);
        return 1 << row_bits;
    endfunction

    // Clock cycles needed to fetch, shift, latch and hold one row.
    function automatic int row_cycles_of(input int col_bits, input int hold_cycles);
        return FETCH_CYCLES + 2 * cols_of(col_bits) + 1 + hold_cycles;
    endfunction

endpackage

// File: rtl/frame_buffer_scanner_if.sv
// RAM read port plus LED driver chain signals seen by the scanner.
interface frame_buffer_scanner_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_BITS   = 4,
    parameter int COL_BITS   = 6
);
    logic [ROW_BITS+COL_BITS-1:0] read_addr;
    logic [DATA_WIDTH-1:0]        ram_data;
    logic [DATA_WIDTH-1:0]        shift_data;
    logic                         shift_clk;
    logic                         latch;
    logic                         blank;
    logic [ROW_BITS-1:0]          row_select;

    // Scanner side: drives the RAM address and the driver chain.
    modport master (
        output read_addr,
        output shift_data,
        output shift_clk,
        output latch,
        output blank,
        output row_select,
        input  ram_data
    );

    // RAM / driver side.
    modport slave (
        input  read_addr,
        input  shift_data,
        input  shift_clk,
        input  latch,
        input  blank,
        input  row_select,
        output ram_data
    );
endinterface

// File: rtl/frame_buffer_scanner.sv
// Read side of the cube frame buffer: sweeps the frame RAM row by row,
// shifts each row into the LED driver chain, latches it and holds it lit
// while the next row is prefetched.
module frame_buffer_scanner
    import scanner_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 6,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   frame_done,
    frame_buffer_scanner_if.master bus
);

    localparam int COLS   = cols_of(COL_BITS);
    localparam int ROWS   = rows_of(ROW_BITS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int ADDR_W = ROW_BITS + COL_BITS;

    localparam logic [COL_BITS-1:0] LAST_COL  = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [HOLD_W-1:0]   LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);

    state_t                  state, state_n;

    logic [ROW_BITS-1:0]     row, row_n;
    logic [COL_BITS-1:0]     col, col_n;
    logic                    phase, phase_n;
    logic                    fetch_cnt, fetch_cnt_n;
    logic [HOLD_W-1:0]       hold_cnt, hold_cnt_n;
    logic                    shown, shown_n;

    logic [ADDR_W-1:0]       read_addr_r, read_addr_n;
    logic [DATA_WIDTH-1:0]   shift_data_r, shift_data_n;
    logic                    shift_clk_r, shift_clk_n;
    logic                    latch_r, latch_n;
    logic                    blank_r, blank_n;
    logic [ROW_BITS-1:0]     row_select_r, row_select_n;
    logic                    frame_done_r, frame_done_n;

    assign bus.read_addr  = read_addr_r;
    assign bus.shift_data = shift_data_r;
    assign bus.shift_clk  = shift_clk_r;
    assign bus.latch      = latch_r;
    assign bus.blank      = blank_r;
    assign bus.row_select = row_select_r;
    assign frame_done     = frame_done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and next values of every registered output and counter.
    // Actions are tied to the edge that enters a phase: the FETCH exit edge
    // is also the phase-0 edge of column 0, so the RAM word for {row,col}
    // is sampled exactly two edges after its address was presented.
    always_comb begin
        state_n      = state;
        row_n        = row;
        col_n        = col;
        phase_n      = phase;
        fetch_cnt_n  = fetch_cnt;
        hold_cnt_n   = hold_cnt;
        shown_n      = shown;
        read_addr_n  = read_addr_r;
        shift_data_n = shift_data_r;
        shift_clk_n  = shift_clk_r;
        latch_n      = 1'b0;
        blank_n      = blank_r;
        row_select_n = row_select_r;
        frame_done_n = 1'b0;

        case (state)
            IDLE: begin
                // Driver dark and quiet; row counter and row_select are kept.
                read_addr_n  = '0;
                shift_data_n = '0;
                shift_clk_n  = 1'b0;
                blank_n      = 1'b1;
                shown_n      = 1'b0;
                if (enable) begin
                    state_n     = FETCH;
                    fetch_cnt_n = 1'b0;
                    read_addr_n = {row, {COL_BITS{1'b0}}};
                end
            end

            FETCH: begin
                if (fetch_cnt) begin
                    state_n      = SHIFT;
                    col_n        = '0;
                    phase_n      = 1'b0;
                    shift_data_n = bus.ram_data;
                    shift_clk_n  = 1'b0;
                    read_addr_n  = {row, COL_BITS'(1)};
                end else begin
                    fetch_cnt_n = 1'b1;
                end
            end

            SHIFT: begin
                if (!phase) begin
                    // Data has been stable for a cycle; raise the shift clock.
                    shift_clk_n = 1'b1;
                    phase_n     = 1'b1;
                end else if (col == LAST_COL) begin
                    state_n      = LATCH;
                    shift_clk_n  = 1'b0;
                    latch_n      = 1'b1;
                    blank_n      = 1'b1;
                    row_select_n = row;
                    shown_n      = 1'b1;
                end else begin
                    // Next column: present its word and prefetch the one after.
                    col_n        = col + 1'b1;
                    phase_n      = 1'b0;
                    shift_data_n = bus.ram_data;
                    shift_clk_n  = 1'b0;
                    read_addr_n  = {row, col + COL_BITS'(2)};
                end
            end

            LATCH: begin
                state_n    = HOLD;
                hold_cnt_n = '0;
                blank_n    = 1'b0;
            end

            HOLD: begin
                if (hold_cnt == LAST_HOLD) begin
                    row_n = row + 1'b1;
                    if (row == LAST_ROW) begin
                        frame_done_n = 1'b1;
                    end
                    if (enable) begin
                        // Keep the latched row lit while the next one loads.
                        state_n     = FETCH;
                        fetch_cnt_n = 1'b0;
                        read_addr_n = {row + 1'b1, {COL_BITS{1'b0}}};
                        blank_n     = ~shown;
                    end else begin
                        state_n      = IDLE;
                        read_addr_n  = '0;
                        shift_data_n = '0;
                        shift_clk_n  = 1'b0;
                        blank_n      = 1'b1;
                        shown_n      = 1'b0;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Counters and registered outputs; reset forces the dark idle picture.
    always_ff @(posedge clk) begin
        if (reset) begin
            row          <= '0;
            col          <= '0;
            phase        <= 1'b0;
            fetch_cnt    <= 1'b0;
            hold_cnt     <= '0;
            shown        <= 1'b0;
            read_addr_r  <= '0;
            shift_data_r <= '0;
            shift_clk_r  <= 1'b0;
            latch_r      <= 1'b0;
            blank_r      <= 1'b1;
            row_select_r <= '0;
            frame_done_r <= 1'b0;
        end else begin
            row          <= row_n;
            col          <= col_n;
            phase        <= phase_n;
            fetch_cnt    <= fetch_cnt_n;
            hold_cnt     <= hold_cnt_n;
            shown        <= shown_n;
            read_addr_r  <= read_addr_n;
            shift_data_r <= shift_data_n;
            shift_clk_r  <= shift_clk_n;
            latch_r      <= latch_n;
            blank_r      <= blank_n;
            row_select_r <= row_select_n;
            frame_done_r <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_frame_buffer_scanner.sv
// Bench for frame_buffer_scanner: behavioural frame RAM, a row-level
// scoreboard that reassembles each shifted row and compares it with a
// shadow copy of the RAM at latch time, and directed/random scan control.
module tb_frame_buffer_scanner;

    localparam int DW       = 8;
    localparam int RB       = 2;
    localparam int CB       = 2;
    localparam int HOLD     = 3;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int NWORDS   = ROWS * COLS;
    localparam int SHIFT_LEN = 2 + 2 * COLS;            // enable edge to latch edge
    localparam int ROW_PER  = 2 + 2 * COLS + 1 + HOLD;  // 14
    localparam int FRAME    = ROWS * ROW_PER;           // 56

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic frame_done;

    logic          we;
    logic [3:0]    waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mem [NWORDS];
    logic [DW-1:0] mirror [NWORDS];

    int n_checks = 0;
    int n_errors = 0;

    int pcnt = 0;
    bit mon_on = 1'b0;
    bit sb_clear = 1'b0;

    // scoreboard state (monitor-owned)
    logic [DW-1:0] got_q [$];
    int  lat_q [$];
    int  exp_row = 0;
    int  latch_cnt = 0;
    int  fd_cnt = 0;
    int  fd_edge = 0;
    int  hold_left = 0;
    bit  any_latch = 1'b0;
    logic prev_sclk = 1'b0;

    frame_buffer_scanner_if #(.DATA_WIDTH(DW), .ROW_BITS(RB), .COL_BITS(CB)) bus ();

    frame_buffer_scanner #(
        .DATA_WIDTH (DW),
        .ROW_BITS   (RB),
        .COL_BITS   (CB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .frame_done(frame_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt++;

    // Frame RAM: registered read of the registered address, read-old on collision.
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        bus.ram_data <= mem[bus.read_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row-level monitor: collects words on shift_clk rises, checks on latch.
    always @(negedge clk) begin
        if (sb_clear) begin
            got_q.delete();
            exp_row   = 0;
            any_latch = 1'b0;
            hold_left = 0;
        end else if (mon_on) begin
            if (hold_left > 0) begin
                chk("blank_hold", bus.blank, 1'b0);
                hold_left--;
            end
            if (!any_latch) chk("blank_prelatch", bus.blank, 1'b1);
            if (bus.shift_clk && !prev_sclk) got_q.push_back(bus.shift_data);
            if (bus.latch) begin
                chk("latch_sclk", bus.shift_clk, 1'b0);
                chk("latch_blank", bus.blank, 1'b1);
                chk("latch_row", bus.row_select, exp_row);
                chk("row_words", got_q.size(), COLS);
                for (int i = 0; i < COLS && i < got_q.size(); i++)
                    chk($sformatf("row%0d_word%0d", exp_row, i), got_q[i], mirror[exp_row * COLS + i]);
                exp_row = (exp_row + 1) % ROWS;
                got_q.delete();
                latch_cnt++;
                lat_q.push_back(pcnt);
                any_latch = 1'b1;
                hold_left = HOLD;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_edge = pcnt;
            end
        end
        prev_sclk = bus.shift_clk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_latch(input int budget);
        int start;
        int k;
        start = latch_cnt;
        k = 0;
        while (latch_cnt == start && k < budget) begin
            step();
            k++;
        end
        chk("latch_arrives", (latch_cnt != start), 1'b1);
    endtask

    // Called just after a latch is seen: random RAM writes and enable toggles
    // through HOLD; only the last enable value reaches the HOLD exit edge.
    task automatic hold_activity();
        int a;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, NWORDS - 1);
                we = 1'b1;
                waddr = 4'(a);
                wdata = 8'($urandom_range(0, 255));
                mirror[a] = wdata;
            end else begin
                we = 1'b0;
            end
            enable = 1'($urandom_range(0, 1));
            step();
        end
        we = 1'b0;
    endtask

    initial begin
        int first_fetch;
        int rel_edge;
        int nlat;
        reset = 1'b1;
        enable = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;

        // Load word = address while held in reset.
        step();
        for (int i = 0; i < NWORDS; i++) begin
            we = 1'b1;
            waddr = 4'(i);
            wdata = 8'(i);
            mirror[i] = 8'(i);
            step();
        end
        we = 1'b0;
        step();

        chk("rst_read_addr", bus.read_addr, 0);
        chk("rst_shift_data", bus.shift_data, 0);
        chk("rst_shift_clk", bus.shift_clk, 0);
        chk("rst_latch", bus.latch, 0);
        chk("rst_blank", bus.blank, 1);
        chk("rst_row_select", bus.row_select, 0);
        chk("rst_frame_done", frame_done, 0);

        // First row and one full frame.
        mon_on = 1'b1;
        reset = 1'b0;
        enable = 1'b1;
        first_fetch = pcnt + 1;
        for (int r = 0; r < 5; r++) wait_latch(40);
        chk("first_latch_delay", lat_q[0] - first_fetch, SHIFT_LEN);
        for (int i = 1; i < 5; i++) chk($sformatf("row_period%0d", i), lat_q[i] - lat_q[i-1], ROW_PER);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_done_delay", fd_edge - first_fetch, FRAME);

        // Drop enable during SHIFT of row 1; write 0xAA to {2,1} in its HOLD.
        repeat (8) step();
        enable = 1'b0;
        wait_latch(40);
        we = 1'b1;
        waddr = 4'd9;
        wdata = 8'hAA;
        mirror[9] = 8'hAA;
        step();
        we = 1'b0;
        repeat (3) step();
        chk("idle_blank", bus.blank, 1);
        chk("idle_read_addr", bus.read_addr, 0);
        chk("idle_row_select", bus.row_select, 1);
        nlat = latch_cnt;
        repeat (10) step();
        chk("idle_no_latch", latch_cnt, nlat);
        chk("idle_blank_kept", bus.blank, 1);
        enable = 1'b1;
        wait_latch(40);
        chk("resume_row_select", bus.row_select, 2);

        // Random writes and enable toggles through many rows.
        for (int r = 0; r < 12; r++) begin
            hold_activity();
            if (!enable) begin
                chk("rand_idle_blank", bus.blank, 1);
                chk("rand_idle_sclk", bus.shift_clk, 0);
                repeat ($urandom_range(0, 4)) step();
                enable = 1'b1;
            end
            wait_latch(60);
        end

        // Reset in the middle of SHIFT.
        enable = 1'b1;
        repeat (7) step();
        reset = 1'b1;
        step();
        chk("midrst_read_addr", bus.read_addr, 0);
        chk("midrst_shift_clk", bus.shift_clk, 0);
        chk("midrst_blank", bus.blank, 1);
        chk("midrst_latch", bus.latch, 0);
        chk("midrst_row_select", bus.row_select, 0);
        sb_clear = 1'b1;
        reset = 1'b0;
        rel_edge = pcnt + 1;
        step();
        sb_clear = 1'b0;
        wait_latch(40);
        chk("midrst_latch_delay", lat_q[$] - rel_edge, SHIFT_LEN);
        wait_latch(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected $finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/frame_buffer_scanner.md
# frame_buffer_scanner

Read side of the cube frame buffer. It sweeps the read port of the simple dual-port frame RAM one row at a time and shifts each row's words out to the LED driver chain. It then latches the row and holds it lit while the next row is prefetched. The write side (SPI/host loader) fills the same RAM independently.

## Interface
Parameters:
- DATA_WIDTH, 8: width of one RAM word and of the parallel shift bus.
- ROW_BITS, 4: row index width; ROWS = 2**ROW_BITS.
- COL_BITS, 6: column index width; COLS = 2**COL_BITS words per row.
- HOLD_CYCLES, 16: lit-hold cycles per row after latch; must be at least 1.

Ports:
- clk, input, 1: single clock; the RAM shares it.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: level; 1 = scan continuously.
- read_addr, output, ROW_BITS+COL_BITS: registered RAM read address, {row, col}.
- ram_data, input, DATA_WIDTH: RAM data_out.
- shift_data, output, DATA_WIDTH: registered word to the driver chain.
- shift_clk, output, 1: driver shift clock; the driver samples on its rising edge.
- latch, output, 1: one-cycle pulse transferring the shifted row to the driver outputs.
- blank, output, 1: 1 = driver outputs off.
- row_select, output, ROW_BITS: row currently displayed.
- frame_done, output, 1: one-cycle pulse when the last row's hold ends.

## Operation
Reset values:
- State IDLE.
- read_addr 0, shift_data 0, shift_clk 0, latch 0, blank 1, row_select 0, frame_done 0.
- Internal row and col counters 0; shown flag 0.

States:
- IDLE: outputs at their reset values except row_select, which holds. If enable=1, go to FETCH and load read_addr <= {row,0}.
- FETCH: lasts exactly 2 cycles to cover the RAM's registered-address latency. Then go to SHIFT, phase 0, col=0.
- SHIFT: two cycles per column.
  - Phase-0 edge: shift_data <= ram_data (word {row,col}), shift_clk <= 0, read_addr <= {row,col+1}. col+1 wraps within COL_BITS; the wrapped fetch is harmless.
  - Phase-1 edge: shift_clk <= 1.
  - After the phase-1 edge of col=COLS-1, go to LATCH.
- LATCH: one cycle. latch=1, blank=1, shift_clk=0, row_select <= row, shown <= 1.
- HOLD: HOLD_CYCLES cycles. blank=0, latch=0.
  - On exit, row <= row+1, wrapping modulo ROWS.
  - When row wraps from ROWS-1 to 0, pulse frame_done in the cycle after the last hold cycle.
  - Next state is FETCH if enable=1, else IDLE.

Blank rule:
- blank=1 in IDLE and LATCH.
- blank=1 in FETCH and SHIFT while shown=0; shown is cleared on entry to IDLE.
- blank=0 otherwise.

Boundary conditions:
- enable deasserted mid-row: the row completes through HOLD, then goes to IDLE. The row counter is kept, so the next enable resumes at the next row.
- enable toggled 1→0→1 while in HOLD: only the value at HOLD exit matters.
- Writes to the RAM during a scan are not blocked. A word written to address A is visible if the write edge precedes the cycle in which A is presented on read_addr by at least one edge.
- reset asserted in any state: all outputs return to reset values on the next edge; no partial latch is issued.

## Timing
- RAM read latency: ram_data is valid for the address on read_addr two edges after read_addr updates.
- Cycles per row: 2 + 2·COLS + 1 + HOLD_CYCLES. At defaults: 2+128+1+16 = 147 cycles.
- Frame period: ROWS times the row cycles (2352 at defaults).
- shift_data is stable for both cycles of each shift_clk period. The rising shift_clk occurs one cycle after the data change.
- latch is never asserted in the same cycle as shift_clk=1.

## Structure
- Package scanner_pkg:
  - state enum {IDLE, FETCH, SHIFT, LATCH, HOLD};
  - localparam functions for COLS, ROWS and ROW_CYCLES.
- No sub-module. The block is a single FSM plus row, col, phase and hold counters. The frame RAM is instantiated beside it at the top level, not inside it.

## Test plan
Bench parameters: ROW_BITS=2, COL_BITS=2, HOLD_CYCLES=3, driven by a behavioural RAM model with 2-edge latency. The RAM is loaded with word = address.

- Reset, then enable=1:
  - 4 shift_clk rises carry shift_data 0,1,2,3.
  - latch pulses with row_select=0.
  - Row period is 14 cycles.
- Run a full frame:
  - row_select goes 0,1,2,3.
  - frame_done pulses once, 56 cycles after the first FETCH.
  - The scan resumes at row 0.
- Drop enable during SHIFT of row 1:
  - row 1 still latches and completes HOLD, then enters IDLE with blank=1.
  - Re-enable: the next latched row_select is 2.
- Write 0xAA to address {2,1} while row 1 is in HOLD:
  - row 2 shifts 8, 0xAA, 10, 11.
- Assert reset mid-SHIFT:
  - next cycle: read_addr=0, shift_clk=0, blank=1, latch=0.
  - no latch pulse appears until a full new row has been shifted.
- Blank coverage: blank=1 until the first latch, blank=1 in every LATCH cycle, and blank=0 in every HOLD cycle.
